aggregate_sched: RTL and testbench

- Frame-level controller for the Ethernet RX aggregation stage.
- Sequences the aggregator per frame: flushes it between frames, enforces an inter-frame gap, and rejects short and oversize frames.
- Captures each frame's 32-bit aggregated word into a small FIFO and hands it to one downstream consumer (seven-segment / logic-analyzer capture) over valid/ready.
- Sits between the aggregator output and the display/capture logic.

---
 rtl/aggregate_sched_pkg.sv | 26 ++
 rtl/sched_fifo.sv | 71 +++++++
 rtl/aggregate_sched.sv | 181 ++++++++++++++++++
 tb/tb_aggregate_sched.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aggregate_sched_pkg.sv
// aggregate_sched_pkg: shared types and helpers
// for the RX aggregation frame scheduler.
package aggregate_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_DISCARD,
        S_GAP
    } state_e;

    localparam int AGR_WORD_W = 32;
    localparam int DIBIT_W    = 2;
    localparam int CNT_MAX_W  = 32;

    // Increment v, sticking at the all-ones value of a w-bit counter.
    function automatic logic [CNT_MAX_W-1:0] sat_inc(
        input logic [CNT_MAX_W-1:0] v,
        input int                   w
    );
        logic [CNT_MAX_W-1:0] lim;
        lim = (CNT_MAX_W'(1) << w) - CNT_MAX_W'(1);
        return (v >= lim) ? v : v + CNT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/sched_fifo.sv
// sched_fifo: DEPTH x W synchronous FIFO with a
// registered head word and same-cycle push/pop.
module sched_fifo
    import aggregate_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = AGR_WORD_W
) (
    input  logic         clk,
    input  logic         rst_n_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic [W-1:0]  head_q, head_d;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign dout_o  = head_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Next occupancy and next head word.
    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (do_push && (empty_o || (do_pop && cnt_q == 1)))
            head_d = din_i;
        else if (do_pop && cnt_q > 1)
            head_d = mem_q[rd_q + AW'(1)];
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_q] <= din_i;
    end

    // Pointers, occupancy and head register.
    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            if (do_push)
                wr_q <= wr_q + AW'(1);
            if (do_pop)
                rd_q <= rd_q + AW'(1);
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
    end

endmodule

// File: rtl/aggregate_sched.sv
// aggregate_sched: per-frame sequencing of the RX
// aggregator, word capture and frame statistics.
module aggregate_sched
    import aggregate_sched_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int GAP        = 12,
    parameter int MAX_DIBITS = 760,
    parameter int CW         = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  axiiv,
    input  logic [DIBIT_W-1:0]    axiid,
    input  logic [AGR_WORD_W-1:0] agg_d,
    input  logic                  agg_v,
    output logic                  agg_rst,
    output logic [AGR_WORD_W-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CW-1:0]         n_ok,
    output logic [CW-1:0]         n_short,
    output logic [CW-1:0]         n_drop,
    output logic                  busy
);

    localparam int DCW = $clog2(MAX_DIBITS + 1);
    localparam int GCW = $clog2(GAP + 1);

    state_e         state_q, state_d;
    logic [DCW-1:0] dib_cnt_q, dib_cnt_d;
    logic [GCW-1:0] gap_cnt_q, gap_cnt_d;
    logic           got_q, got_d;
    logic           lost_q, lost_d;
    logic           agg_rst_q, agg_rst_d;
    logic           axiiv_q;
    logic [CW-1:0]  n_ok_q, n_short_q, n_drop_q;
    logic           inc_ok, inc_short, inc_drop;
    logic           take, push, pop;
    logic           fifo_full, fifo_empty;

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign take      = (state_q == S_RECV) && agg_v && !got_q;
    assign push      = take && (!fifo_full || pop);
    assign agg_rst   = agg_rst_q;
    assign busy      = (state_q != S_IDLE);
    assign n_ok      = n_ok_q;
    assign n_short   = n_short_q;
    assign n_drop    = n_drop_q;

    sched_fifo #(
        .DEPTH (DEPTH),
        .W     (AGR_WORD_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n_i (rst),
        .push_i  (push),
        .din_i   (agg_d),
        .pop_i   (pop),
        .dout_o  (out_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state: a frame already in flight when we
    // become ready is never joined mid-stream.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:
                if (en && axiiv)
                    state_d = axiiv_q ? S_DISCARD : S_RECV;
            S_RECV:
                if (!axiiv)
                    state_d = S_GAP;
                else if (dib_cnt_q == DCW'(MAX_DIBITS - 1))
                    state_d = S_DISCARD;
            S_DISCARD:
                if (!axiiv)
                    state_d = S_GAP;
            S_GAP:
                if (axiiv)
                    state_d = S_DISCARD;
                else if (gap_cnt_q == GCW'(GAP - 1))
                    state_d = S_IDLE;
            default:
                state_d = S_IDLE;
        endcase
    end

    // Outputs and per-frame bookkeeping.
    always_comb begin
        dib_cnt_d = dib_cnt_q;
        gap_cnt_d = '0;
        got_d     = got_q;
        lost_d    = lost_q;
        inc_ok    = 1'b0;
        inc_short = 1'b0;
        inc_drop  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                dib_cnt_d = DCW'(1);
                got_d     = 1'b0;
                lost_d    = 1'b0;
            end
            S_RECV: begin
                if (take) begin
                    got_d  = 1'b1;
                    lost_d = lost_q || !push;
                end
                if (!axiiv) begin
                    if (got_d && !lost_d)
                        inc_ok = 1'b1;
                    else if (got_d)
                        inc_drop = 1'b1;
                    else
                        inc_short = 1'b1;
                end else begin
                    dib_cnt_d = dib_cnt_q + DCW'(1);
                    if (dib_cnt_q == DCW'(MAX_DIBITS - 1))
                        inc_drop = 1'b1;
                end
            end
            S_GAP:
                gap_cnt_d = gap_cnt_q + GCW'(1);
            default: ;
        endcase
        agg_rst_d = (state_d == S_IDLE && !en) ||
                    (state_d == S_GAP) ||
                    (state_d == S_DISCARD);
    end

    // Frame bookkeeping registers and saturating stats.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dib_cnt_q <= '0;
            gap_cnt_q <= '0;
            got_q     <= 1'b0;
            lost_q    <= 1'b0;
            agg_rst_q <= 1'b1;
            n_ok_q    <= '0;
            n_short_q <= '0;
            n_drop_q  <= '0;
        end else begin
            dib_cnt_q <= dib_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            got_q     <= got_d;
            lost_q    <= lost_d;
            agg_rst_q <= agg_rst_d;
            if (inc_ok)
                n_ok_q <= CW'(sat_inc(CNT_MAX_W'(n_ok_q), CW));
            if (inc_short)
                n_short_q <= CW'(sat_inc(CNT_MAX_W'(n_short_q), CW));
            if (inc_drop)
                n_drop_q <= CW'(sat_inc(CNT_MAX_W'(n_drop_q), CW));
        end
    end

    // Envelope history; kept through reset so a frame
    // still running when reset lifts is not joined.
    always_ff @(posedge clk) begin
        axiiv_q <= axiiv;
    end

    // The dibit lane must carry known data inside a frame.
    always_ff @(posedge clk) begin
        if (rst && axiiv)
            assert (!$isunknown(axiid));
    end

endmodule

// File: tb/tb_aggregate_sched.sv
// tb_aggregate_sched: randomized + directed scoreboard
// bench for aggregate_sched.
module tb_aggregate_sched;

    localparam int DEPTH = 4;
    localparam int GAP   = 12;
    localparam int MAXD  = 760;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          axiiv;
    logic [1:0]    axiid;
    logic [31:0]   agg_d;
    logic          agg_v;
    logic          agg_rst;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] n_ok, n_short, n_drop;
    logic          busy;

    aggregate_sched #(
        .DEPTH      (DEPTH),
        .GAP        (GAP),
        .MAX_DIBITS (MAXD),
        .CW         (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .axiiv     (axiiv),
        .axiid     (axiid),
        .agg_d     (agg_d),
        .agg_v     (agg_v),
        .agg_rst   (agg_rst),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .n_ok      (n_ok),
        .n_short   (n_short),
        .n_drop    (n_drop),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          nvalid = 0;
    int          npop   = 0;
    int          m_ok   = 0;
    int          m_short = 0;
    int          m_drop = 0;
    int          mode   = 0;
    logic [31:0] sb[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, ".n_ok"}, 32'(n_ok), 32'(m_ok));
        chk({tag, ".n_short"}, 32'(n_short), 32'(m_short));
        chk({tag, ".n_drop"}, 32'(n_drop), 32'(m_drop));
    endtask

    // Monitor: pops the scoreboard on every handshake.
    always @(negedge clk) begin
        if (rst && out_valid)
            nvalid++;
        if (rst && out_valid && out_ready) begin
            npop++;
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_word: got %0h expected none",
                         out_data);
            end else begin
                chk("out_data", out_data, sb.pop_front());
            end
        end
    end

    // One cycle of stimulus. A word offered while the model
    // FIFO is full only survives if a pop frees a slot.
    task automatic cyc(input logic v, input logic av,
                       input logic [31:0] ad, input bit live,
                       output logic acc);
        if (mode == 2)
            out_ready = 1'($urandom_range(0, 1));
        else
            out_ready = (mode == 1);
        acc = live && av && (sb.size() < DEPTH || out_ready);
        if (acc)
            sb.push_back(ad);
        axiiv = v;
        axiid = 2'($urandom);
        agg_v = av;
        agg_d = av ? ad : $urandom;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++)
            cyc(1'b0, 1'b0, 32'h0, 1'b0, a);
    endtask

    // Whole frame of L dibits, agg_v at cycle p (0: none;
    // p==L lands on the falling cycle), then post idle.
    task automatic frame(input int L, input int p,
                         input logic [31:0] w, input bit live,
                         input int post);
        logic a;
        bit   got;
        got = 0;
        for (int i = 0; i <= L; i++) begin
            cyc(i < L, p != 0 && i == p, w, live, a);
            got |= a;
        end
        if (live) begin
            if (L >= MAXD)
                m_drop++;
            else if (p == 0)
                m_short++;
            else if (got)
                m_ok++;
            else
                m_drop++;
        end
        idle(post);
    endtask

    initial begin
        int v0, r0, p0;
        logic a;
        rst = 1'b0; en = 1'b0; axiiv = 1'b0; axiid = 2'b0;
        agg_d = '0; agg_v = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_data", out_data, 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.agg_rst", 32'(agg_rst), 32'd1);
        chk_cnt("rst");
        rst = 1'b1;
        idle(2);
        chk("idle_dis.agg_rst", 32'(agg_rst), 32'd1);
        en = 1'b1;
        idle(3);
        chk("idle_en.agg_rst", 32'(agg_rst), 32'd0);

        // Nominal frame, consumer always ready.
        mode = 1;
        v0 = nvalid;
        r0 = 0;
        for (int i = 0; i <= 100; i++) begin
            cyc(i < 100, i == 32, 32'hDEADBEEF, 1'b1, a);
            if (i == 50)
                chk("nom.agg_rst_recv", 32'(agg_rst), 32'd0);
        end
        m_ok++;
        r0 += int'(agg_rst);
        for (int i = 0; i < GAP + 4; i++) begin
            idle(1);
            r0 += int'(agg_rst);
        end
        chk("nom.agg_rst_cycles", 32'(r0), 32'(GAP));
        chk("nom.valid_cycles", 32'(nvalid - v0), 32'd1);
        chk_cnt("nom");

        // Short frame.
        v0 = nvalid;
        frame(20, 0, 32'h0, 1'b1, GAP + 2);
        chk("short.valid_cycles", 32'(nvalid - v0), 32'd0);
        chk("short.busy", 32'(busy), 32'd0);
        chk_cnt("short");

        // Back-pressure: five words into a four-deep FIFO.
        mode = 0;
        for (int k = 1; k <= 5; k++)
            frame(40, 10, 32'(k), 1'b1, GAP + 2);
        chk_cnt("bp");
        chk("bp.sb_depth", 32'(sb.size()), 32'(DEPTH));
        mode = 1;
        p0 = npop;
        idle(4);
        chk("bp.pops", 32'(npop - p0), 32'd4);
        idle(2);

        // Oversize frame.
        for (int i = 0; i <= 800; i++) begin
            cyc(i < 800, 1'b0, 32'h0, 1'b1, a);
            if (i == 770) begin
                chk("big.n_drop", 32'(n_drop), 32'(m_drop + 1));
                chk("big.agg_rst", 32'(agg_rst), 32'd1);
            end
        end
        m_drop++;
        idle(GAP + 2);
        chk_cnt("big");
        chk("big.busy", 32'(busy), 32'd0);

        // Gap violation, then a legal frame.
        frame(30, 12, 32'hA5A50001, 1'b1, 5);
        frame(30, 12, 32'hBADBAD00, 1'b0, GAP + 2);
        chk_cnt("gapv");
        frame(30, 12, 32'hA5A50002, 1'b1, GAP + 2);
        chk_cnt("gapok");

        // Mid-frame reset with two words queued.
        mode = 0;
        frame(30, 5, 32'h11, 1'b1, GAP + 2);
        frame(30, 5, 32'h22, 1'b1, GAP + 2);
        for (int i = 0; i < 40; i++)
            cyc(1'b1, 1'b0, 32'h0, 1'b1, a);
        rst = 1'b0;
        cyc(1'b1, 1'b0, 32'h0, 1'b1, a);
        sb.delete();
        m_ok = 0; m_short = 0; m_drop = 0;
        chk("mrst.out_valid", 32'(out_valid), 32'd0);
        chk("mrst.agg_rst", 32'(agg_rst), 32'd1);
        chk("mrst.busy", 32'(busy), 32'd0);
        chk_cnt("mrst");
        rst = 1'b1;
        mode = 1;
        for (int i = 0; i < 40; i++)
            cyc(1'b1, i == 10, 32'hFEEDF00D, 1'b0, a);
        idle(GAP + 2);
        chk("mrst.discard_valid", 32'(out_valid), 32'd0);
        chk_cnt("mrst_tail");
        frame(30, 7, 32'hC0FFEE00, 1'b1, GAP + 2);
        chk_cnt("mrst_next");

        // Randomized frames with random back-pressure.
        mode = 2;
        for (int k = 0; k < 40; k++) begin
            int L, p;
            L = $urandom_range(4, 60);
            p = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, L);
            frame(L, p, $urandom, 1'b1, GAP + 2 + $urandom_range(0, 5));
        end
        mode = 1;
        for (int i = 0; i < 30 && sb.size() != 0; i++)
            idle(1);
        idle(2);
        chk("rand.drained", 32'(sb.size()), 32'd0);
        chk("rand.out_valid", 32'(out_valid), 32'd0);
        chk_cnt("rand");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
